card_dealer: RTL and testbench
==============================

Name: card_dealer

Overview:
Downstream consumer of the shuffled 52-entry card deck RAM. On each deal request it reads the next deck slot, decodes the 6-bit card ID into suit, rank and blackjack point value, and presents it with a one-cycle valid pulse to the game FSM. It tracks the deck pointer, stalls while a shuffle is in progress, and reports deck exhaustion.

Parameters:
DECK_SIZE, 52, number of valid deck slots; card IDs 0..DECK_SIZE-1.
READ_LAT, 2, deck RAM read latency in cycles from Address stable to DataOut valid (1..3).
RESHUFFLE_THRESH, 15, remaining-card count at or below which reshuffle_req asserts (optional feature only).

Ports:
Clock  in  1  system clock; all logic on its rising edge.
Reset  in  1  synchronous, active-high reset.
shuffleOn  in  1  shuffle in progress; dealer must not drive or read the RAM while high.
new_deck  in  1  one-cycle pulse: deck pointer back to 0 (issued after a shuffle completes).
deal_req  in  1  level request for the next card; sampled in IDLE only.
Address  out  6  deck RAM read address.
DataOut  in  6  deck RAM read data (card ID).
card_valid  out  1  one-cycle pulse: card outputs valid this cycle.
card_id  out  6  raw card ID read.
suit  out  2  card_id / 13.
rank  out  4  card_id mod 13; 0 = Ace, 12 = King.
points  out  4  blackjack value: Ace 11, ranks 1..9 give rank+1, ranks 10..12 give 10.
is_ace  out  1  rank == 0.
card_err  out  1  card ID >= DECK_SIZE; qualified by card_valid.
deck_empty  out  1  pointer == DECK_SIZE.
cards_left  out  6  DECK_SIZE minus pointer.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE; pointer 0; Address 6'b111111; card_valid, card_err and busy 0; card_id, suit, rank, points and is_ace 0; deck_empty 0; cards_left DECK_SIZE.
- FSM states: IDLE, ADDR, WAIT, OUT.
- IDLE:
  - new_deck forces pointer to 0; this has priority over deal_req in the same cycle.
  - Go to ADDR when deal_req is high, shuffleOn is low and deck_empty is low.
  - A deal_req while empty or while shuffleOn is high is ignored: no pulse, the request stays pending.
- ADDR: drive Address = pointer; load the wait counter with READ_LAT-1; go to WAIT.
- WAIT: hold Address; decrement the counter; at 0, capture DataOut into card_id and go to OUT.
  - Latency: deal_req accepted in IDLE at cycle N gives card_valid at cycle N+2+READ_LAT.
- OUT:
  - card_valid high for exactly one cycle.
  - Decoded outputs are registered from card_id and hold until the next deal.
  - pointer increments, saturating at DECK_SIZE.
  - Address returns to 6'b111111; return to IDLE.
  - A new request needs one IDLE cycle, so back-to-back deals are spaced by at least READ_LAT+3 cycles.
- shuffleOn rising while in ADDR or WAIT: abort to IDLE, no card_valid, pointer unchanged, Address 6'b111111.
- new_deck outside IDLE is latched and applied on the next entry to IDLE.
- Decode arithmetic: subtract-13 compare chain on the 6-bit ID; no divider.
  - For IDs 52..63: card_err = 1, suit = 3, rank = 15, points = 0.
- deck_empty and cards_left are combinational from pointer.
- Reset mid-operation returns to the reset state on the next edge.
- The dealer never writes the RAM; write enable stays owned by the shuffler.

Optional Feature:
AUTO_RESHUFFLE_EN.
- Defined: adds output reshuffle_req (1 bit, reset 0).
  - It pulses one cycle when cards_left falls to RESHUFFLE_THRESH or below as the result of a deal, or when deck_empty becomes 1.
  - It fires at most once per deck and re-arms on new_deck.
- Undefined: the port and logic are absent; deck exhaustion is signalled only by deck_empty.

Decomposition:
- Package card_pkg holds:
  - DECK_SIZE and SUITS = 4 / RANKS = 13.
  - The rank encoding constants RANK_ACE = 0 and RANK_KING = 12.
  - The typedef for the FSM state enum.
  - The invalid-card sentinel 6'b111111.
- Sub-module card_decode: combinational card ID to {suit, rank, points, is_ace, card_err}. It is reusable by the hand-scoring block.

Test Plan:
1. Reset, preload RAM slot 0 = 6'd0, pulse deal_req -> card_valid at N+4 (READ_LAT 2); card_id 0, suit 0, rank 0, points 11, is_ace 1; cards_left 51.
2. Slot value 6'd25 -> suit 1, rank 12, points 10. Slot value 6'd40 -> suit 3, rank 1, points 2.
3. Deal 52 cards -> deck_empty 1, cards_left 0. A 53rd deal_req gives no card_valid; new_deck restores cards_left to 52.
4. Raise shuffleOn during WAIT -> no card_valid, pointer unchanged, Address 6'b111111. After shuffleOn falls, the same slot is re-read.
5. Slot value 6'd60 -> card_err 1, rank 15, points 0; pointer still advances.
6. With AUTO_RESHUFFLE_EN, deal 37 cards -> reshuffle_req pulses once, on the deal that makes cards_left 15. No second pulse before new_deck.

Source files
------------

// File: rtl/card_pkg.sv
// Shared constants and types for the card dealer and card scoring logic.
package card_pkg;

    localparam int DECK_SIZE = 52;
    localparam int SUITS     = 4;
    localparam int RANKS     = 13;

    localparam logic [3:0] RANK_ACE  = 4'd0;
    localparam logic [3:0] RANK_KING = 4'd12;
    localparam logic [3:0] RANK_NONE = 4'd15;

    localparam logic [5:0] CARD_NONE = 6'b111111;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        OUT
    } state_t;

endpackage

// File: rtl/card_decode.sv
// Combinational card ID decode into suit, rank, points, ace and error flags.
module card_decode
    import card_pkg::*;
(
    input  logic [5:0] card_id,
    output logic [1:0] suit,
    output logic [3:0] rank,
    output logic [3:0] points,
    output logic       is_ace,
    output logic       card_err
);

    logic [5:0] residue;

    // Repeated subtract-13 instead of a divider
    always_comb begin
        suit     = 2'd3;
        rank     = RANK_NONE;
        points   = 4'd0;
        is_ace   = 1'b0;
        card_err = 1'b0;
        residue  = card_id;
        if (card_id >= 6'(DECK_SIZE)) begin
            card_err = 1'b1;
        end else begin
            suit = 2'd0;
            for (int s = 0; s < SUITS - 1; s++) begin
                if (residue >= 6'(RANKS)) begin
                    residue = residue - 6'(RANKS);
                    suit    = suit + 2'd1;
                end
            end
            rank   = residue[3:0];
            is_ace = (rank == RANK_ACE);
            if (is_ace)
                points = 4'd11;
            else if (rank >= 4'd10 && rank <= RANK_KING)
                points = 4'd10;
            else
                points = rank + 4'd1;
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Deals cards from the shuffled deck RAM and decodes them for the game FSM.
// Optional AUTO_RESHUFFLE_EN adds a one-shot reshuffle_req per deck.
module card_dealer
    import card_pkg::*;
#(
    parameter int READ_LAT = 2
`ifdef AUTO_RESHUFFLE_EN
    ,
    parameter int RESHUFFLE_THRESH = 15
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       shuffleOn,
    input  logic       new_deck,
    input  logic       deal_req,
    output logic [5:0] Address,
    input  logic [5:0] DataOut,
    output logic       card_valid,
    output logic [5:0] card_id,
    output logic [1:0] suit,
    output logic [3:0] rank,
    output logic [3:0] points,
    output logic       is_ace,
    output logic       card_err,
    output logic       deck_empty,
    output logic [5:0] cards_left,
`ifdef AUTO_RESHUFFLE_EN
    output logic       reshuffle_req,
`endif
    output logic       busy
);

    state_t     state;
    logic [5:0] ptr;
    logic [5:0] ptr_next;
    logic [1:0] cnt;
    logic       nd_pend;
    logic       apply_nd;

    logic [1:0] dec_suit;
    logic [3:0] dec_rank;
    logic [3:0] dec_points;
    logic       dec_ace;
    logic       dec_err;

    card_decode u_decode (
        .card_id  (DataOut),
        .suit     (dec_suit),
        .rank     (dec_rank),
        .points   (dec_points),
        .is_ace   (dec_ace),
        .card_err (dec_err)
    );

    assign deck_empty = (ptr == 6'(DECK_SIZE));
    assign cards_left = 6'(DECK_SIZE) - ptr;
    assign ptr_next   = deck_empty ? ptr : ptr + 6'd1;
    assign busy       = (state != IDLE);
    assign apply_nd   = new_deck || nd_pend;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            nd_pend    <= 1'b0;
            Address    <= CARD_NONE;
            card_valid <= 1'b0;
            card_id    <= '0;
            suit       <= '0;
            rank       <= '0;
            points     <= '0;
            is_ace     <= 1'b0;
            card_err   <= 1'b0;
        end else begin
            card_valid <= 1'b0;
            if (new_deck && state != IDLE)
                nd_pend <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (apply_nd) begin
                        ptr     <= '0;
                        nd_pend <= 1'b0;
                    end else if (deal_req && !shuffleOn && !deck_empty) begin
                        Address <= ptr;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (shuffleOn) begin
                        Address <= CARD_NONE;
                        state   <= IDLE;
                        if (apply_nd) begin
                            ptr     <= '0;
                            nd_pend <= 1'b0;
                        end
                    end else begin
                        Address <= ptr;
                        cnt     <= 2'(READ_LAT - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (shuffleOn) begin
                        Address <= CARD_NONE;
                        state   <= IDLE;
                        if (apply_nd) begin
                            ptr     <= '0;
                            nd_pend <= 1'b0;
                        end
                    end else if (cnt == 2'd0) begin
                        // Decode is registered alongside the raw ID
                        card_id    <= DataOut;
                        suit       <= dec_suit;
                        rank       <= dec_rank;
                        points     <= dec_points;
                        is_ace     <= dec_ace;
                        card_err   <= dec_err;
                        card_valid <= 1'b1;
                        ptr        <= ptr_next;
                        state      <= OUT;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                OUT: begin
                    Address <= CARD_NONE;
                    state   <= IDLE;
                    if (apply_nd) begin
                        ptr     <= '0;
                        nd_pend <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef AUTO_RESHUFFLE_EN
    logic armed;
    logic capture;

    assign capture = (state == WAIT) && !shuffleOn && (cnt == 2'd0);

    // Pointer at zero means a fresh deck, so that is where the one-shot re-arms
    always_ff @(posedge Clock) begin
        if (Reset) begin
            armed         <= 1'b1;
            reshuffle_req <= 1'b0;
        end else begin
            reshuffle_req <= 1'b0;
            if (ptr == 6'd0)
                armed <= 1'b1;
            if (capture && armed &&
                (6'(DECK_SIZE) - ptr_next) <= 6'(RESHUFFLE_THRESH)) begin
                reshuffle_req <= 1'b1;
                armed         <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_card_dealer.sv
// Directed and randomized bench for card_dealer against a deck/decode model.
module tb_card_dealer;

    localparam int RL   = 2;
    localparam int DECK = 52;

    logic       clk = 1'b0;
    logic       rst;
    logic       shuffle_on;
    logic       new_deck;
    logic       deal_req;
    logic [5:0] address;
    logic [5:0] data_out;
    logic       card_valid;
    logic [5:0] card_id;
    logic [1:0] suit;
    logic [3:0] rank;
    logic [3:0] points;
    logic       is_ace;
    logic       card_err;
    logic       deck_empty;
    logic [5:0] cards_left;
    logic       busy;
`ifdef AUTO_RESHUFFLE_EN
    logic       reshuffle_req;
`endif

    card_dealer #(.READ_LAT(RL)) dut (
        .Clock      (clk),
        .Reset      (rst),
        .shuffleOn  (shuffle_on),
        .new_deck   (new_deck),
        .deal_req   (deal_req),
        .Address    (address),
        .DataOut    (data_out),
        .card_valid (card_valid),
        .card_id    (card_id),
        .suit       (suit),
        .rank       (rank),
        .points     (points),
        .is_ace     (is_ace),
        .card_err   (card_err),
        .deck_empty (deck_empty),
        .cards_left (cards_left),
`ifdef AUTO_RESHUFFLE_EN
        .reshuffle_req (reshuffle_req),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Deck RAM model: data appears RL cycles after the address
    logic [5:0] mem [64];
    logic [5:0] addr_pipe [RL];
    always @(posedge clk) begin
        addr_pipe[0] <= address;
        for (int i = 1; i < RL; i++)
            addr_pipe[i] <= addr_pipe[i-1];
    end
    assign data_out = mem[addr_pipe[RL-1]];

    int checks = 0;
    int errors = 0;
    int ref_ptr = 0;
    int ref_deals = 0;
    int cv_count = 0;
    int rs_count = 0;
    int rs_left = -1;

    always @(negedge clk) begin
        if (card_valid) cv_count++;
`ifdef AUTO_RESHUFFLE_EN
        if (reshuffle_req) begin
            rs_count++;
            rs_left = int'(cards_left);
        end
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check({tag, ".idle_timeout"}, 1, 0);
    endtask

    task automatic do_deal(input string tag, input bit nd_mid);
        int id, es, er, ep, ee, lat;
        bit seen;
        id = int'(mem[ref_ptr]);
        if (id < DECK) begin
            es = id / 13;
            er = id % 13;
            ep = (er == 0) ? 11 : ((er >= 10) ? 10 : er + 1);
            ee = 0;
        end else begin
            es = 3; er = 15; ep = 0; ee = 1;
        end
        wait_idle(tag);
        @(negedge clk);
        deal_req = 1'b1;
        seen = 1'b0;
        lat = 0;
        while (!seen && lat < 12) begin
            @(negedge clk);
            lat++;
            if (lat == 1) deal_req = 1'b0;
            if (nd_mid && lat == 2) new_deck = 1'b1;
            if (nd_mid && lat == 3) new_deck = 1'b0;
            seen = card_valid;
        end
        check({tag, ".seen"}, 32'(seen), 1);
        if (seen) begin
            ref_deals++;
            if (ref_ptr < DECK) ref_ptr++;
            check({tag, ".latency"}, lat, RL + 2);
            check({tag, ".id"}, 32'(card_id), id);
            check({tag, ".suit"}, 32'(suit), es);
            check({tag, ".rank"}, 32'(rank), er);
            check({tag, ".points"}, 32'(points), ep);
            check({tag, ".ace"}, 32'(is_ace), (er == 0) ? 1 : 0);
            check({tag, ".err"}, 32'(card_err), ee);
            check({tag, ".left"}, 32'(cards_left), DECK - ref_ptr);
            @(negedge clk);
            check({tag, ".pulse1"}, 32'(card_valid), 0);
            check({tag, ".hold"}, 32'(card_id), id);
            if (nd_mid) begin
                ref_ptr = 0;
                check({tag, ".nd_left"}, 32'(cards_left), DECK);
            end
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        int n, vc, bc;
        rst = 1'b1;
        shuffle_on = 1'b0;
        new_deck = 1'b0;
        deal_req = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 6'($urandom_range(0, 63));
        mem[0] = 6'd0;
        mem[1] = 6'd25;
        mem[2] = 6'd40;
        mem[3] = 6'd60;
        repeat (3) @(negedge clk);
        check("rst.addr", 32'(address), 63);
        check("rst.valid", 32'(card_valid), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.left", 32'(cards_left), DECK);
        check("rst.empty", 32'(deck_empty), 0);
        check("rst.id", 32'(card_id), 0);
        check("rst.points", 32'(points), 0);
        check("rst.err", 32'(card_err), 0);
        rst = 1'b0;
        @(negedge clk);

        do_deal("ace", 1'b0);
        do_deal("id25", 1'b0);
        do_deal("id40", 1'b0);
        do_deal("id60", 1'b0);
        do_deal("rand", 1'b0);

        // Abort a read in WAIT with shuffleOn
        wait_idle("abort");
        @(negedge clk);
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        @(negedge clk);
        shuffle_on = 1'b1;
        deal_req = 1'b1;
        vc = 0;
        bc = 0;
        repeat (6) begin
            @(negedge clk);
            if (card_valid) vc++;
            if (busy) bc++;
        end
        check("abort.valid", vc, 0);
        check("abort.busy", bc, 0);
        check("abort.addr", 32'(address), 63);
        check("abort.left", 32'(cards_left), DECK - ref_ptr);
        shuffle_on = 1'b0;
        deal_req = 1'b0;
        do_deal("reread", 1'b0);

        // new_deck during WAIT is applied once the card is out
        do_deal("nd_mid", 1'b1);

        while (ref_ptr < DECK) do_deal("run", 1'b0);
        wait_idle("empty");
        check("empty.flag", 32'(deck_empty), 1);
        check("empty.left", 32'(cards_left), 0);
`ifdef AUTO_RESHUFFLE_EN
        check("rs.count", rs_count, 1);
        check("rs.left", rs_left, 15);
`endif

        // Request while empty stays pending until new_deck
        @(negedge clk);
        deal_req = 1'b1;
        vc = 0;
        bc = 0;
        repeat (10) begin
            @(negedge clk);
            if (card_valid) vc++;
            if (busy) bc++;
        end
        check("extra.valid", vc, 0);
        check("extra.busy", bc, 0);
        new_deck = 1'b1;
        @(negedge clk);
        new_deck = 1'b0;
        ref_ptr = 0;
        check("nd.left", 32'(cards_left), DECK);
        check("nd.priority", 32'(busy), 0);
        n = 0;
        while (!card_valid && n < 12) begin
            @(negedge clk);
            n++;
            if (busy) deal_req = 1'b0;
        end
        deal_req = 1'b0;
        check("pend.seen", 32'(card_valid), 1);
        if (card_valid) begin
            ref_deals++;
            ref_ptr = 1;
            check("pend.id", 32'(card_id), 32'(mem[0]));
            check("pend.left", 32'(cards_left), DECK - 1);
        end
        repeat (4) @(negedge clk);
`ifdef AUTO_RESHUFFLE_EN
        check("rs.once", rs_count, 1);
`endif
        check("total.pulses", cv_count, ref_deals);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
